// File: rtl/payload_receiver_pkg.sv
// Shared definitions for the event/payload link: event-code bytes and the
// receive parser state encoding.
package payload_receiver_pkg;

  localparam logic [7:0] EVT_END_GAME    = 8'hAE;
  localparam logic [7:0] EVT_START_GAME  = 8'hA1;
  localparam logic [7:0] EVT_PLAYER_MOVE = 8'hB2;

  typedef enum logic {
    AGUARDA_CODIGO = 1'b0,
    RECEBENDO      = 1'b1
  } rx_state_t;

endpackage

// File: rtl/payload_receiver_inactivity_timer.sv
// Counts consecutive enabled cycles since the last clear; o_expired is asserted on
// the cycle whose edge would bring the count to TIMEOUT_CYCLES.
module inactivity_timer
  import payload_receiver_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned     TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // A clear in the same cycle wins over expiry.
  assign o_expired = i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/payload_receiver.sv
// Waits for EVENT_CODE on the UART RX byte stream, then gathers RECV_BYTES_QTD
// payload bytes into buffer_recepcao (first byte in the MSBs) and pulses completion.
module payload_receiver
  import payload_receiver_pkg::*;
#(
  parameter logic [7:0]  EVENT_CODE     = EVT_END_GAME,
  parameter int unsigned RECV_BYTES_QTD = 1,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          habilitar_recepcao,
  input  logic [7:0]                    dado_entrada,
  input  logic                          dado_recebido,
  output logic [8*RECV_BYTES_QTD-1:0]   buffer_recepcao,
  output logic                          recepcao_concluida,
  output logic                          recepcao_ocupada,
  output logic                          erro_timeout
);

  localparam int unsigned   BW        = 8 * RECV_BYTES_QTD;
  localparam int unsigned   CW        = $clog2(RECV_BYTES_QTD + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(RECV_BYTES_QTD - 1);

  rx_state_t     r_state, w_state_next;
  logic [CW-1:0] r_count, w_count_next;
  logic [BW-1:0] r_buffer;
  logic [BW-1:0] w_shadow_next;
  logic          r_concluida, r_erro;
  logic          w_done, w_timeout;
  logic          w_timer_en, w_timer_clear, w_expired;

  assign w_timer_en    = (r_state == RECEBENDO) && habilitar_recepcao;
  assign w_timer_clear = dado_recebido || (r_state != RECEBENDO);

  inactivity_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  // Shadow keeps only the earlier payload bytes; the final byte goes straight to the buffer.
  generate
    if (RECV_BYTES_QTD == 1) begin : g_single
      assign w_shadow_next = dado_entrada;
    end else begin : g_multi
      logic [BW-9:0] r_shadow;
      always_ff @(posedge clock) begin
        if ((r_state == RECEBENDO) && habilitar_recepcao && dado_recebido) begin
          r_shadow <= w_shadow_next[BW-9:0];
        end
      end
      assign w_shadow_next = {r_shadow, dado_entrada};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      AGUARDA_CODIGO: begin
        if (dado_recebido && habilitar_recepcao && (dado_entrada == EVENT_CODE)) begin
          w_state_next = RECEBENDO;
          w_count_next = '0;
        end
      end
      RECEBENDO: begin
        if (!habilitar_recepcao) begin
          w_state_next = AGUARDA_CODIGO;
          w_count_next = '0;
        end else if (dado_recebido) begin
          if (r_count == LAST_BYTE) begin
            w_done       = 1'b1;
            w_state_next = AGUARDA_CODIGO;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + 1'b1;
          end
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = AGUARDA_CODIGO;
          w_count_next = '0;
        end
      end
      default: begin
        w_state_next = AGUARDA_CODIGO;
        w_count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= AGUARDA_CODIGO;
      r_count     <= '0;
      r_buffer    <= '0;
      r_concluida <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_concluida <= w_done;
      r_erro      <= w_timeout;
      if (w_done) begin
        r_buffer <= w_shadow_next;
      end
    end
  end

  assign buffer_recepcao    = r_buffer;
  assign recepcao_concluida = r_concluida;
  assign recepcao_ocupada   = (r_state == RECEBENDO);
  assign erro_timeout       = r_erro;

endmodule

// File: tb/tb_payload_receiver.sv
// Drives two receivers (1-byte default and 3-byte/100-cycle-timeout) from one byte
// stream and compares both against a frame-level reference model every cycle.
module tb_payload_receiver;

  localparam int NB [2] = '{1, 3};
  localparam int TO [2] = '{50_000_000, 100};

  logic        clock = 1'b0;
  logic        reset;
  logic        hab;
  logic        strobe;
  logic [7:0]  dado;

  logic [7:0]  a_buf;
  logic        a_done, a_busy, a_err;
  logic [23:0] b_buf;
  logic        b_done, b_busy, b_err;

  int n_checks = 0;
  int n_errors = 0;

  payload_receiver u_a (
    .clock              (clock),
    .reset              (reset),
    .habilitar_recepcao (hab),
    .dado_entrada       (dado),
    .dado_recebido      (strobe),
    .buffer_recepcao    (a_buf),
    .recepcao_concluida (a_done),
    .recepcao_ocupada   (a_busy),
    .erro_timeout       (a_err)
  );

  payload_receiver #(
    .EVENT_CODE     (8'hAE),
    .RECV_BYTES_QTD (3),
    .TIMEOUT_CYCLES (100)
  ) u_b (
    .clock              (clock),
    .reset              (reset),
    .habilitar_recepcao (hab),
    .dado_entrada       (dado),
    .dado_recebido      (strobe),
    .buffer_recepcao    (b_buf),
    .recepcao_concluida (b_done),
    .recepcao_ocupada   (b_busy),
    .erro_timeout       (b_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view (header seen, bytes collected, idle cycles)
  bit          m_busy  [2];
  int          m_n     [2];
  int          m_idle  [2];
  logic [7:0]  m_bytes [2][3];
  logic [31:0] m_buf   [2];
  bit          m_done  [2];
  bit          m_err   [2];

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 0; m_n[k] = 0; m_idle[k] = 0;
        m_buf[k] = 0; m_done[k] = 0; m_err[k] = 0;
      end else begin
        m_done[k] = 0;
        m_err[k]  = 0;
        if (!m_busy[k]) begin
          if (strobe && hab && dado == 8'hAE) begin
            m_busy[k] = 1; m_n[k] = 0; m_idle[k] = 0;
          end
        end else if (!hab) begin
          m_busy[k] = 0;
        end else if (strobe) begin
          m_bytes[k][m_n[k]] = dado;
          m_n[k]++;
          m_idle[k] = 0;
          if (m_n[k] == NB[k]) begin
            m_buf[k] = 0;
            for (int i = 0; i < NB[k]; i++)
              m_buf[k] = m_buf[k] | ({24'b0, m_bytes[k][i]} << (8 * (NB[k] - 1 - i)));
            m_done[k] = 1;
            m_busy[k] = 0;
          end
        end else begin
          m_idle[k]++;
          if (m_idle[k] >= TO[k]) begin
            m_err[k]  = 1;
            m_busy[k] = 0;
          end
        end
      end
    end
  end

  int cnt_done [2] = '{0, 0};
  int cnt_err  [2] = '{0, 0};

  always @(negedge clock) begin
    check("a_buffer",    {24'b0, a_buf},  m_buf[0]);
    check("a_concluida", {31'b0, a_done}, {31'b0, m_done[0]});
    check("a_ocupada",   {31'b0, a_busy}, {31'b0, m_busy[0]});
    check("a_erro",      {31'b0, a_err},  {31'b0, m_err[0]});
    check("b_buffer",    {8'b0, b_buf},   m_buf[1]);
    check("b_concluida", {31'b0, b_done}, {31'b0, m_done[1]});
    check("b_ocupada",   {31'b0, b_busy}, {31'b0, m_busy[1]});
    check("b_erro",      {31'b0, b_err},  {31'b0, m_err[1]});
    cnt_done[0] += int'(a_done);
    cnt_done[1] += int'(b_done);
    cnt_err[0]  += int'(a_err);
    cnt_err[1]  += int'(b_err);
  end

  // Called at a negedge; presents one byte strobe and returns at the next negedge.
  task automatic send(input logic [7:0] b);
    dado   = b;
    strobe = 1'b1;
    @(negedge clock);
    strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic abort_frame();
    hab = 1'b0;
    @(negedge clock);
    hab = 1'b1;
    @(negedge clock);
  endtask

  int sd0, sd1, se0, se1;

  initial begin
    reset = 1'b1; hab = 1'b0; strobe = 1'b0; dado = 8'h00;
    idle(3);
    check("rst_a_buffer", {24'b0, a_buf}, 32'h0);
    check("rst_b_buffer", {8'b0, b_buf}, 32'h0);
    check("rst_strobes",  {28'b0, a_done, a_err, b_done, b_err}, 32'h0);
    check("rst_ocupada",  {30'b0, a_busy, b_busy}, 32'h0);
    reset = 1'b0;
    hab   = 1'b1;
    idle(2);

    // 1: AE,85 on the 1-byte receiver
    send(8'hAE);
    check("t1_a_busy", {31'b0, a_busy}, 32'h1);
    send(8'h85);
    check("t1_a_done",   {31'b0, a_done}, 32'h1);
    check("t1_a_buffer", {24'b0, a_buf},  32'h85);
    check("t1_model",    m_buf[0],        32'h85);
    idle(1);
    check("t1_a_done_low", {31'b0, a_done}, 32'h0);
    abort_frame();

    // 2: junk bytes before the header are ignored
    sd0 = cnt_done[0]; se0 = cnt_err[0];
    send(8'h12); send(8'h34); send(8'hAE); send(8'h07);
    idle(1);
    check("t2_a_buffer",   {24'b0, a_buf}, 32'h07);
    check("t2_done_count", cnt_done[0] - sd0, 32'd1);
    check("t2_err_count",  cnt_err[0] - se0,  32'd0);
    abort_frame();

    // 3: event code inside the payload is plain data
    send(8'hAE); send(8'hAE); send(8'h01); send(8'h02);
    check("t3_b_done",   {31'b0, b_done}, 32'h1);
    check("t3_b_buffer", {8'b0, b_buf},   32'hAE0102);
    check("t3_model",    m_buf[1],        32'hAE0102);
    abort_frame();

    // 4: inter-byte timeout on the 3-byte receiver
    send(8'hAE); send(8'h01);
    idle(99);
    check("t4_no_err_yet", {31'b0, b_err},  32'h0);
    check("t4_still_busy", {31'b0, b_busy}, 32'h1);
    idle(1);
    check("t4_err",        {31'b0, b_err},  32'h1);
    check("t4_busy_low",   {31'b0, b_busy}, 32'h0);
    check("t4_buffer",     {8'b0, b_buf},   32'hAE0102);
    idle(2);

    // 5: disable aborts silently; reset mid-frame clears everything
    sd0 = cnt_done[0]; sd1 = cnt_done[1]; se0 = cnt_err[0]; se1 = cnt_err[1];
    send(8'hAE);
    hab = 1'b0;
    @(negedge clock);
    send(8'h55);
    idle(1);
    check("t5_busy",   {30'b0, a_busy, b_busy}, 32'h0);
    check("t5_pulses", (cnt_done[0] - sd0) + (cnt_done[1] - sd1) + (cnt_err[0] - se0) + (cnt_err[1] - se1), 32'd0);
    hab = 1'b1;
    send(8'hAE);
    check("t5_rearmed", {30'b0, a_busy, b_busy}, 32'h3);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_buffers", {a_buf, b_buf}, 32'h0);
    check("t5_rst_outs",    {26'b0, a_done, a_busy, a_err, b_done, b_busy, b_err}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    idle(2);

    // Randomized stream: mixed headers, data, disables and long gaps
    for (int i = 0; i < 4000; i++) begin
      hab    = ($urandom_range(0, 49) != 0);
      strobe = ($urandom_range(0, 2) == 0);
      dado   = ($urandom_range(0, 3) == 0) ? 8'hAE : 8'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        strobe = 1'b0;
        hab    = 1'b1;
        idle($urandom_range(90, 110));
      end else begin
        @(negedge clock);
      end
    end
    strobe = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
